// File: rtl/program_mem_arbiter_if.sv
// Bundle of the cache-facing fill ports and the program-memory read port.
// The arbiter uses the slave view; caches plus the memory controller use the master view.
interface program_mem_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int READ_NUM      = 4
);
  logic [NUM_CONSUMERS-1:0]                    consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0]          consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                    consumer_read_ready;
  logic [NUM_CONSUMERS*READ_NUM*DATA_BITS-1:0] consumer_read_data;
  logic                                        mem_read_valid;
  logic [ADDR_BITS-1:0]                        mem_read_address;
  logic                                        mem_read_ready;
  logic [READ_NUM*DATA_BITS-1:0]               mem_read_data;

  modport slave (
    input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );

  modport master (
    output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among the per-core
// instruction caches; one fill transaction in flight at a time, all outputs registered.
module program_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int READ_NUM      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  program_mem_arbiter_if.slave  bus
);
  localparam int LINE_BITS = READ_NUM * DATA_BITS;
  localparam int IDX_W     = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND,
    RELEASE
  } state_e;

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]                   grant_q, grant_d;
  logic                               memValid_q, memValid_d;
  logic [ADDR_BITS-1:0]               memAddr_q, memAddr_d;
  logic [NUM_CONSUMERS-1:0]           ready_q, ready_d;
  logic [NUM_CONSUMERS*LINE_BITS-1:0] data_q, data_d;

  logic             found;
  logic [IDX_W-1:0] pick;
  int               cand;

  // Search starts just after the last winner so the previous grantee has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      cand = (int'(rrPtr_q) + k) % NUM_CONSUMERS;
      if (!found && bus.consumer_read_valid[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    grant_d    = grant_q;
    memValid_d = memValid_q;
    memAddr_d  = memAddr_q;
    ready_d    = '0;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick;
          rrPtr_d    = pick;
          memValid_d = 1'b1;
          memAddr_d  = bus.consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_read_ready) begin
          memValid_d                                = 1'b0;
          data_d[grant_q*LINE_BITS +: LINE_BITS]    = bus.mem_read_data;
          ready_d[grant_q]                          = 1'b1;
          state_d                                   = RESPOND;
        end
      end
      RESPOND: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        // The cache drops valid one cycle late; waiting here avoids re-granting a served request.
        if (!bus.consumer_read_valid[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rrPtr_q    <= IDX_W'(NUM_CONSUMERS - 1);
      grant_q    <= '0;
      memValid_q <= 1'b0;
      memAddr_q  <= '0;
      ready_q    <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      grant_q    <= grant_d;
      memValid_q <= memValid_d;
      memAddr_q  <= memAddr_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
    end
  end

  assign bus.mem_read_valid      = memValid_q;
  assign bus.mem_read_address    = memAddr_q;
  assign bus.consumer_read_ready = ready_q;
  assign bus.consumer_read_data  = data_q;
endmodule
